// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper pulse generator.
// Holds the axis FSM state encoding, the speed-field geometry, the
// direction-bit location, the DIR reset value, and two small helpers
// (tick clamping and soft-limit blocking) used by stepper_axis.
package stepper_pkg;

    // Axis sequencing states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,  // stopped, or the next step is blocked by a limit
        SETUP    = 2'd1,  // DIR changed, waiting for it to settle
        PULSE_HI = 2'd2,  // STEP high
        PULSE_LO = 2'd3   // remainder of the step period
    } state_t;

    // Width of the S field taken from the speed register.
    localparam int S_WIDTH = 16;

    // Bit of the direction register that selects positive motion.
    localparam int DIR_BIT = 0;

    // DIR pin value out of reset (positive direction).
    localparam logic DIR_RESET = 1'b1;

    // Raise a requested tick count to the minimum allowed period.
    function automatic logic [S_WIDTH-1:0] clamp_ticks(
        input logic [S_WIDTH-1:0] s,
        input logic [S_WIDTH-1:0] floor_ticks
    );
        return (s < floor_ticks) ? floor_ticks : s;
    endfunction

    // A step is blocked when it would carry the position past a soft limit.
    function automatic logic step_blocked(
        input logic               dir,
        input logic signed [31:0] pos,
        input logic signed [31:0] pos_min,
        input logic signed [31:0] pos_max
    );
        return dir ? (pos == pos_max) : (pos == pos_min);
    endfunction

endpackage

// File: rtl/stepper_axis_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops
//   d     - asynchronous input
//   q     - synchronized output, two clocks of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/stepper_axis.sv
// Single-axis stepper pulse generator.
// Turns a speed/direction register pair into STEP/DIR/EN pin activity for an
// external stepper driver and keeps the signed axis position, with soft
// limits and an asynchronous home button that zeroes the position.
// Ports:
//   clock      - system clock
//   ctrl_reset - asynchronous active-low reset
//   speed      - [15:0] = S ticks per step (0 = stop), upper bits ignored
//   direction  - bit0 = 1 positive, 0 negative, other bits ignored
//   home       - raw home button, asynchronous
//   step_out   - STEP pin (registered)
//   dir_out    - DIR pin (registered)
//   motor_en   - driver enable, high while not IDLE (registered)
//   position   - signed step count
//   limit_hit  - sticky soft-limit flag
module stepper_axis
    import stepper_pkg::*;
#(
    parameter int                 TICK_DIV  = 1000,
    parameter int                 MIN_TICKS = 2,
    parameter int                 PULSE_W   = 50,
    parameter int                 DIR_SETUP = 100,
    parameter logic signed [31:0] POS_MIN   = -32'sd100000,
    parameter logic signed [31:0] POS_MAX   = 32'sd100000
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] speed,
    input  logic [31:0] direction,
    input  logic        home,
    output logic        step_out,
    output logic        dir_out,
    output logic        motor_en,
    output logic [31:0] position,
    output logic        limit_hit
);

    // The shared counter times both the STEP high phase and DIR settling.
    localparam int PHASE_MAX = (PULSE_W > DIR_SETUP) ? PULSE_W : DIR_SETUP;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [PHASE_W-1:0] PULSE_LAST = PHASE_W'(PULSE_W - 1);
    localparam logic [PHASE_W-1:0] SETUP_LAST = PHASE_W'(DIR_SETUP - 1);
    localparam logic [PHASE_W-1:0] PHASE_ZERO = {PHASE_W{1'b0}};
    localparam logic [S_WIDTH-1:0] MIN_S      = S_WIDTH'(MIN_TICKS);
    localparam logic [S_WIDTH-1:0] S_ZERO     = {S_WIDTH{1'b0}};

    state_t               state_r;
    state_t               state_s;
    logic                 step_out_r;
    logic                 step_out_s;
    logic                 dir_out_r;
    logic                 dir_out_s;
    logic                 motor_en_r;
    logic                 motor_en_s;
    logic signed [31:0]   position_r;
    logic signed [31:0]   position_step_s;
    logic signed [31:0]   position_s;
    logic                 limit_hit_r;
    logic                 limit_step_s;
    logic                 limit_hit_s;
    logic [S_WIDTH-1:0]   s_eff_r;
    logic [S_WIDTH-1:0]   s_eff_s;
    logic [31:0]          period_cnt_r;
    logic [31:0]          period_cnt_s;
    logic [PHASE_W-1:0]   phase_cnt_r;
    logic [PHASE_W-1:0]   phase_cnt_s;
    logic                 try_step_s;

    logic [S_WIDTH-1:0]   s_in_s;
    logic                 dir_bit_s;
    logic [31:0]          period_last_s;
    logic                 home_sync_s;
    logic                 home_dly_r;
    logic                 home_edge_s;
    logic                 unused_bits_s;

    assign s_in_s    = speed[S_WIDTH-1:0];
    assign dir_bit_s = direction[DIR_BIT];

    // Register bits that carry no meaning for this block.
    assign unused_bits_s = &{1'b0, speed[31:S_WIDTH], direction[31:DIR_BIT+1]};

    // Clock count at which the next step slot opens, measured from STEP rise.
    assign period_last_s = (32'(s_eff_r) * 32'(TICK_DIV)) - 32'd1;

    sync2 u_home_sync (
        .clk   (clock),
        .rst_n (ctrl_reset),
        .d     (home),
        .q     (home_sync_s)
    );

    assign home_edge_s = home_sync_s & ~home_dly_r;

    // Delayed copy of the synchronized home level for rising-edge detection.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            home_dly_r <= 1'b0;
        end else begin
            home_dly_r <= home_sync_s;
        end
    end

    // Next-state, counter and pin logic for the axis sequencer.
    always_comb begin
        state_s      = state_r;
        step_out_s   = step_out_r;
        dir_out_s    = dir_out_r;
        s_eff_s      = s_eff_r;
        period_cnt_s = period_cnt_r + 32'd1;
        phase_cnt_s  = phase_cnt_r + PHASE_W'(1);
        try_step_s   = 1'b0;
        position_step_s = position_r;
        limit_step_s    = limit_hit_r;

        case (state_r)
            IDLE: begin
                period_cnt_s = 32'd0;
                phase_cnt_s  = PHASE_ZERO;
                if (s_in_s == S_ZERO) begin
                    state_s = IDLE;
                end else if (dir_bit_s == dir_out_r) begin
                    try_step_s = 1'b1;
                end else begin
                    // DIR moves now; the step waits for it to settle.
                    state_s   = SETUP;
                    dir_out_s = dir_bit_s;
                end
            end

            SETUP: begin
                period_cnt_s = 32'd0;
                if (s_in_s == S_ZERO) begin
                    state_s     = IDLE;
                    phase_cnt_s = PHASE_ZERO;
                end else if (phase_cnt_r == SETUP_LAST) begin
                    phase_cnt_s = PHASE_ZERO;
                    if (dir_bit_s != dir_out_r) begin
                        // Direction moved again while settling: start over.
                        dir_out_s = dir_bit_s;
                    end else begin
                        try_step_s = 1'b1;
                    end
                end else begin
                    state_s = SETUP;
                end
            end

            PULSE_HI: begin
                if (phase_cnt_r == PULSE_LAST) begin
                    // The pulse always completes; a stop takes effect after it.
                    step_out_s  = 1'b0;
                    phase_cnt_s = PHASE_ZERO;
                    if (s_in_s == S_ZERO) begin
                        state_s      = IDLE;
                        period_cnt_s = 32'd0;
                    end else begin
                        state_s = PULSE_LO;
                    end
                end else begin
                    state_s = PULSE_HI;
                end
            end

            PULSE_LO: begin
                phase_cnt_s = PHASE_ZERO;
                if (s_in_s == S_ZERO) begin
                    state_s      = IDLE;
                    period_cnt_s = 32'd0;
                end else if (period_cnt_r == period_last_s) begin
                    if (dir_bit_s == dir_out_r) begin
                        try_step_s = 1'b1;
                    end else begin
                        state_s      = SETUP;
                        dir_out_s    = dir_bit_s;
                        period_cnt_s = 32'd0;
                    end
                end else begin
                    state_s = PULSE_LO;
                end
            end

            default: begin
                state_s      = IDLE;
                step_out_s   = 1'b0;
                period_cnt_s = 32'd0;
                phase_cnt_s  = PHASE_ZERO;
            end
        endcase

        // A step attempt either issues a pulse or is suppressed at a limit.
        // dir_out_r already equals the requested direction here.
        if (try_step_s) begin
            period_cnt_s = 32'd0;
            phase_cnt_s  = PHASE_ZERO;
            if (step_blocked(dir_out_r, position_r, POS_MIN, POS_MAX)) begin
                state_s      = IDLE;
                limit_step_s = 1'b1;
            end else begin
                state_s         = PULSE_HI;
                step_out_s      = 1'b1;
                s_eff_s         = clamp_ticks(s_in_s, MIN_S);
                position_step_s = dir_out_r ? (position_r + 32'sd1) : (position_r - 32'sd1);
                // Any issued step moves away from a limit that was hit.
                limit_step_s    = 1'b0;
            end
        end else begin
            s_eff_s = s_eff_r;
        end

        // Home overrides the step's position update but not its pulse.
        position_s  = home_edge_s ? 32'sd0 : position_step_s;
        limit_hit_s = home_edge_s ? 1'b0 : limit_step_s;
        motor_en_s  = (state_s != IDLE);
    end

    // Sequencer state, counters and registered pin outputs.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_r      <= IDLE;
            step_out_r   <= 1'b0;
            dir_out_r    <= DIR_RESET;
            motor_en_r   <= 1'b0;
            position_r   <= 32'sd0;
            limit_hit_r  <= 1'b0;
            s_eff_r      <= S_ZERO;
            period_cnt_r <= 32'd0;
            phase_cnt_r  <= PHASE_ZERO;
        end else begin
            state_r      <= state_s;
            step_out_r   <= step_out_s;
            dir_out_r    <= dir_out_s;
            motor_en_r   <= motor_en_s;
            position_r   <= position_s;
            limit_hit_r  <= limit_hit_s;
            s_eff_r      <= s_eff_s;
            period_cnt_r <= period_cnt_s;
            phase_cnt_r  <= phase_cnt_s;
        end
    end

    assign step_out  = step_out_r;
    assign dir_out   = dir_out_r;
    assign motor_en  = motor_en_r;
    assign position  = position_r;
    assign limit_hit = limit_hit_r;

endmodule
